spi_flash_responder: RTL and testbench
======================================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on CLK, CS_N and MOSI inputs; legal range 2..3.
REQ-002 SHALL have parameter READ_CMD, default 8'h03: opcode accepted as a read command.
REQ-003 SHALL have port clk, input, 1: single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port CLK, input, 1: SPI serial clock from the initiator; mode 0.
REQ-006 SHALL have port CS_N, input, 1: SPI chip select, active low.
REQ-007 SHALL have port MOSI, input, 1: serial data from the initiator, MSB first.
REQ-008 SHALL have port MISO, output, 1: serial data to the initiator, MSB first.
REQ-009 SHALL have port mem_addr, output, 24: byte address into the backing byte store.
REQ-010 SHALL have port mem_rd, output, 1: one-cycle read strobe to the backing store.
REQ-011 SHALL have port mem_rdata, input, 8: byte from the store, valid exactly 1 clk after mem_rd.
REQ-012 SHALL have port busy, output, 1: high while state is not IDLE.

Function
REQ-013 SHALL pass CLK, CS_N and MOSI each through SYNC_STAGES flops; all edge detection SHALL use the synchronized signals.
REQ-014 SHALL detect an SCK rise or fall when the last two synchronized CLK samples differ; the supported SCK rate is at most clk/8.
REQ-015 SHALL sample MOSI on SCK rises and SHALL update MISO on SCK falls only.
REQ-016 SHALL implement states IDLE, CMD, ADDR, DATA and IGNORE.
REQ-017 SHALL move IDLE->CMD on a synchronized CS_N fall, clearing the 3-bit bit counter.
REQ-018 CMD: after 8 rises, SHALL go to ADDR if the shifted byte equals READ_CMD, otherwise to IGNORE.
REQ-019 ADDR: SHALL shift 24 bits MSB first; on the 24th rise it SHALL load mem_addr, pulse mem_rd for one clk and enter DATA.
REQ-020 SHALL capture mem_rdata into the 8-bit transmit register 1 clk after mem_rd.
REQ-021 DATA: on the first fall after entry, MISO SHALL take tx[7]; on each later fall, MISO SHALL take the next lower bit.
REQ-022 DATA: on the rise of bit 0 of each byte, SHALL set mem_addr to mem_addr+1 (modulo 2^24, so 24'hFFFFFF wraps to 0) and pulse mem_rd.
REQ-023 DATA: the prefetched byte SHALL be loaded so that its bit 7 appears on the next fall; the byte stream SHALL be seamless for an unlimited length.
REQ-024 IGNORE: SHALL hold MISO at 0 and SHALL ignore MOSI until CS_N rises.
REQ-025 A synchronized CS_N rise in any state SHALL force IDLE in the same clk, drive MISO to 0 and abort any pending fetch without a further mem_rd.
REQ-026 If a CS_N rise and an SCK edge are detected in the same clk, the CS_N rise SHALL win and the edge SHALL be discarded.
REQ-027 SCK edges while in IDLE SHALL be ignored.
REQ-028 MISO SHALL be 0 in IDLE, CMD, ADDR and IGNORE.
REQ-029 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-030 On resetn low, the block SHALL asynchronously set: state IDLE, MISO 0, mem_rd 0, mem_addr 0, tx 0, bit counter 0, busy 0, and all synchronizer flops to CS_N=1, CLK=0, MOSI=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer; after release, a new CS_N fall SHALL be required to start again.

Verification
REQ-032 Store mem[i]=i[7:0]; send 03 00 00 10, then clock 32 bits -> MISO bytes 10 11 12 13; mem_rd pulses 4 times (5 if prefetch), mem_addr ends 0x000014.
REQ-033 Send 03 FF FF FE, then read 3 bytes -> data FE FF 00; mem_addr wraps to 0x000000.
REQ-034 Send opcode 0xAB, then 24 more SCK cycles -> state IGNORE, MISO stays 0, no mem_rd, busy stays 1 until CS_N rises.
REQ-035 Raise CS_N after 12 address bits -> IDLE within SYNC_STAGES+1 clk, no mem_rd; a following 03 00 00 05 read returns 05.
REQ-036 Pulse resetn low during DATA -> MISO 0, busy 0 immediately; no further mem_rd until a new CS_N fall and command.
REQ-037 Run SCK at exactly clk/8 with a continuous 16-byte read -> all 16 bytes correct with no gap bits.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read responder: decodes a read opcode plus 24-bit address and streams
// bytes from a byte store with a one-clk read latency, prefetching each next byte.
module spi_flash_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  READ_CMD    = 8'h03
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        CLK,
    input  logic        CS_N,
    input  logic        MOSI,
    output logic        MISO,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StIgnore
    } state_e;

    localparam logic [2:0] SettleCnt = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_d_q;
    logic                   cs_d_q;
    logic [2:0]             settle_q;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;
    logic settled;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [23:0] shift_in;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        fetch_pend_q, fetch_pend_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_d_q     <= 1'b0;
            cs_d_q      <= 1'b1;
            settle_q    <= 3'd0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], CLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_d_q     <= sck_s;
            cs_d_q      <= cs_s;
            if (settle_q != SettleCnt) begin
                settle_q <= settle_q + 3'd1;
            end
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The chain holds reset values until refilled; a CS_N held low through reset is not a fall.
    assign settled  = (settle_q == SettleCnt);
    assign sck_rise = sck_s & ~sck_d_q;
    assign sck_fall = ~sck_s & sck_d_q;
    assign cs_rise  = cs_s & ~cs_d_q;
    assign cs_fall  = ~cs_s & cs_d_q & settled;
    assign shift_in = {shift_q[22:0], mosi_s};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = 1'b0;
        fetch_pend_d = mem_rd_q;

        if (fetch_pend_q) begin
            tx_d = mem_rdata;
        end

        if (cs_rise) begin
            // Deselect beats any SCK edge seen in the same clk and drops an in-flight fetch.
            state_d      = StIdle;
            miso_d       = 1'b0;
            fetch_pend_d = 1'b0;
            tx_d         = tx_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d    = StCmd;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 2'd0;
                    end
                end
                StCmd: begin
                    miso_d = 1'b0;
                    if (sck_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = (shift_in[7:0] == READ_CMD) ? StAddr : StIgnore;
                        end
                    end
                end
                StAddr: begin
                    miso_d = 1'b0;
                    if (sck_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                byte_cnt_d = 2'd0;
                                mem_addr_d = shift_in;
                                mem_rd_d   = 1'b1;
                                state_d    = StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (sck_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end else if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        // Bit 0 of the byte just went out: fetch the next one ahead of its bit 7.
                        if (bit_cnt_q == 3'd7) begin
                            mem_addr_d = mem_addr_q + 24'd1;
                            mem_rd_d   = 1'b1;
                        end
                    end
                end
                StIgnore: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            tx_q         <= 8'd0;
            miso_q       <= 1'b0;
            mem_addr_q   <= 24'd0;
            mem_rd_q     <= 1'b0;
            fetch_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            fetch_pend_q <= fetch_pend_d;
        end
    end

    assign MISO     = miso_q;
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a mode-0 initiator, a byte store with mem[i] = i[7:0],
// and a transaction-level model of the MISO bit stream and the fetch address sequence.
module tb_spi_flash_responder;

    localparam int unsigned SYNC = 2;
    localparam int          HALF = 4;  // clk cycles per SCK half period: SCK = clk/8

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        sck       = 1'b0;
    logic        cs_n      = 1'b1;
    logic        mosi      = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        miso;
    logic        mem_rd;
    logic        busy;
    logic [23:0] mem_addr;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .SYNC_STAGES(SYNC),
        .READ_CMD   (8'h03)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .CLK      (sck),
        .CS_N     (cs_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_addr[7:0];
    end

    // Model: MISO bit expected at each SCK rise, and addresses of the expected fetches.
    logic        exp_bits[$];
    logic [23:0] exp_addrs[$];
    logic        exp_idle = 1'b0;
    string       lit_name[$];
    logic [31:0] lit_act[$];
    logic [31:0] lit_exp[$];
    logic [7:0]  rx_bytes[$];
    int          errors   = 0;
    int          checks   = 0;
    int          rd_count = 0;

    initial begin : compare
        logic        sck_prev;
        logic        rd_prev;
        logic        b;
        logic [23:0] a;
        string       nm;
        logic [31:0] la;
        logic [31:0] le;
        sck_prev = 1'b0;
        rd_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                rd_count++;
                checks++;
                if (exp_addrs.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_addr: mem_rd at mem_addr=%06h, no fetch expected", mem_addr);
                end else begin
                    a = exp_addrs.pop_front();
                    if (mem_addr !== a) begin
                        errors++;
                        $display("FAIL fetch_addr: mem_addr=%06h expected %06h", mem_addr, a);
                    end
                end
                checks++;
                if (rd_prev) begin
                    errors++;
                    $display("FAIL mem_rd_width: mem_rd=1 for 2 clk, expected a 1-clk pulse");
                end
            end
            if (resetn && sck && !sck_prev) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL miso_bit: SCK rise with no bit expected, MISO=%b", miso);
                end else begin
                    b = exp_bits.pop_front();
                    if (miso !== b) begin
                        errors++;
                        $display("FAIL miso_bit: MISO=%b expected %b at %0t", miso, b, $time);
                    end
                end
            end
            if (exp_idle) begin
                checks++;
                if (busy !== 1'b0 || miso !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: busy=%b MISO=%b expected 0 0 at %0t",
                             busy, miso, $time);
                end
            end
            while (lit_name.size() > 0) begin
                nm = lit_name.pop_front();
                la = lit_act.pop_front();
                le = lit_exp.pop_front();
                checks++;
                if (la !== le) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", nm, la, le);
                end
            end
            sck_prev = sck;
            rd_prev  = mem_rd;
        end
    end

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_name.push_back(name);
        lit_act.push_back(act);
        lit_exp.push_back(exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(1'b0);
    endtask

    // Read of n bytes from addr: 32 silent bits, then mem[addr+k] MSB first; n+1 fetches.
    task automatic model_read(input logic [23:0] addr, input int n);
        logic [23:0] a;
        logic [7:0]  d;
        push_zeros(32);
        for (int k = 0; k < n; k++) begin
            a = addr + 24'(k);
            d = a[7:0];
            for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
        end
        for (int k = 0; k <= n; k++) exp_addrs.push_back(addr + 24'(k));
    endtask

    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) tick();
            sck = 1'b1;
            rx  = {rx[30:0], miso};
            repeat (HALF) tick();
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        exp_idle = 1'b0;
        cs_n     = 1'b0;
    endtask

    // Outputs must be idle within SYNC+1 clk of the deselect.
    task automatic cs_high();
        repeat (HALF) tick();
        cs_n = 1'b1;
        repeat (SYNC + 1) tick();
        exp_idle = 1'b1;
    endtask

    task automatic do_read(input logic [23:0] addr, input int n);
        logic [31:0] r;
        model_read(addr, n);
        rx_bytes.delete();
        cs_low();
        spi_bits({8'h03, addr}, 32, r);
        for (int k = 0; k < n; k++) begin
            spi_bits(32'h0000_005A, 8, r);
            rx_bytes.push_back(r[7:0]);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int          rd0;
        logic [31:0] r;

        resetn = 1'b0;
        repeat (3) tick();
        expect_eq("reset_busy", 32'(busy), 32'd0);
        expect_eq("reset_miso", 32'(miso), 32'd0);
        expect_eq("reset_mem_rd", 32'(mem_rd), 32'd0);
        expect_eq("reset_mem_addr", 32'(mem_addr), 32'd0);
        resetn   = 1'b1;
        exp_idle = 1'b1;
        repeat (4) tick();

        // 03 00 00 10, four bytes
        rd0 = rd_count;
        do_read(24'h000010, 4);
        expect_eq("r1_byte0", 32'(rx_bytes[0]), 32'h10);
        expect_eq("r1_byte1", 32'(rx_bytes[1]), 32'h11);
        expect_eq("r1_byte2", 32'(rx_bytes[2]), 32'h12);
        expect_eq("r1_byte3", 32'(rx_bytes[3]), 32'h13);
        expect_eq("r1_busy", 32'(busy), 32'd1);
        cs_high();
        expect_eq("r1_fetches", 32'(rd_count - rd0), 32'd5);
        expect_eq("r1_end_addr", 32'(mem_addr), 32'h000014);
        expect_eq("r1_model_drained", 32'(exp_bits.size() + exp_addrs.size()), 32'd0);

        // 03 FF FF FE, three bytes; the fetch address passes through 000000, and the
        // prefetch after the last byte leaves 000001
        rd0 = rd_count;
        do_read(24'hFFFFFE, 3);
        expect_eq("r2_byte0", 32'(rx_bytes[0]), 32'hFE);
        expect_eq("r2_byte1", 32'(rx_bytes[1]), 32'hFF);
        expect_eq("r2_byte2", 32'(rx_bytes[2]), 32'h00);
        cs_high();
        expect_eq("r2_fetches", 32'(rd_count - rd0), 32'd4);
        expect_eq("r2_end_addr", 32'(mem_addr), 32'h000001);

        // Unknown opcode AB plus 24 cycles
        rd0 = rd_count;
        push_zeros(32);
        cs_low();
        spi_bits({8'hAB, 24'h030000}, 32, r);
        expect_eq("ign_miso_bits", r, 32'd0);
        expect_eq("ign_busy", 32'(busy), 32'd1);
        cs_high();
        expect_eq("ign_fetches", 32'(rd_count - rd0), 32'd0);

        // Deselect after 12 address bits, then 03 00 00 05
        rd0 = rd_count;
        push_zeros(20);
        cs_low();
        spi_bits(32'h0000_3000, 20, r);
        cs_high();
        expect_eq("abort_fetches", 32'(rd_count - rd0), 32'd0);
        do_read(24'h000005, 1);
        expect_eq("abort_then_read", 32'(rx_bytes[0]), 32'h05);
        cs_high();

        // Reset in the middle of the third data byte, CS_N held low throughout
        model_read(24'h000100, 3);
        cs_low();
        spi_bits({8'h03, 24'h000100}, 32, r);
        spi_bits(32'd0, 8, r);
        expect_eq("rst_byte0", 32'(r[7:0]), 32'h00);
        spi_bits(32'd0, 8, r);
        expect_eq("rst_byte1", 32'(r[7:0]), 32'h01);
        spi_bits(32'd0, 4, r);
        resetn = 1'b0;
        #1;
        expect_eq("rst_busy", 32'(busy), 32'd0);
        expect_eq("rst_miso", 32'(miso), 32'd0);
        expect_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
        exp_bits.delete();
        exp_addrs.delete();
        exp_idle = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (2) tick();
        rd0 = rd_count;
        push_zeros(32);
        spi_bits({8'h03, 24'h000040}, 32, r);
        expect_eq("rst_no_fetch", 32'(rd_count - rd0), 32'd0);
        expect_eq("rst_busy_after", 32'(busy), 32'd0);
        cs_n = 1'b1;
        repeat (SYNC + 2) tick();
        do_read(24'h000020, 1);
        expect_eq("rst_then_read", 32'(rx_bytes[0]), 32'h20);
        cs_high();

        // Continuous 16-byte read at clk/8, crossing a 256-byte boundary
        rd0 = rd_count;
        do_read(24'h0000F8, 16);
        for (int k = 0; k < 16; k++) begin
            expect_eq($sformatf("burst_byte%0d", k), 32'(rx_bytes[k]), 32'((8'hF8 + k) % 256));
        end
        cs_high();
        expect_eq("burst_fetches", 32'(rd_count - rd0), 32'd17);
        expect_eq("burst_end_addr", 32'(mem_addr), 32'h000108);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
